// File: rtl/bottle_fill_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bottle_fill_counter
//  Description : Counting engine between the hopper pulse detector and the
//                bottling control FSM. Counts hopper pulses into a BCD pill
//                count for the current bottle, counts completed bottles in
//                BCD, flags bottle-full / batch-done and runs a sticky
//                hopper-starvation watchdog while filling.
//  Ports       :
//    clk_1khz       in   1   system clock, 1 kHz
//    switch_clr     in   1   reset, asynchronous, active-low
//    clear          in   1   synchronous clear, same effect as reset
//    count_en       in   1   high while the control FSM is in RUNNING
//    hopper_pulse   in   1   one-cycle pulse per pill dropped
//    bottle_ack     in   1   one-cycle pulse: next bottle in place
//    target_pills   in  12   BCD {hundreds,tens,ones}
//    target_bottles in   8   BCD {tens,ones}
//    now_pills      out 12   BCD pills in current bottle
//    now_bottles    out  8   BCD bottles completed
//    bottle_full    out  1   high in FULL
//    batch_done     out  1   high in DONE
//    starve         out  1   hopper watchdog expired (sticky)
//    state_o        out  2   IDLE=0 FILL=1 FULL=2 DONE=3
//  Revision    : 1.0 - initial release
// ============================================================================
module bottle_fill_counter #(
    parameter int HOPPER_TIMEOUT = 3000,
    parameter int TMR_W          = 12
) (
    input  logic        clk_1khz,
    input  logic        switch_clr,
    input  logic        clear,
    input  logic        count_en,
    input  logic        hopper_pulse,
    input  logic        bottle_ack,
    input  logic [11:0] target_pills,
    input  logic [7:0]  target_bottles,
    output logic [11:0] now_pills,
    output logic [7:0]  now_bottles,
    output logic        bottle_full,
    output logic        batch_done,
    output logic        starve,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [TMR_W-1:0] c_wd_max = TMR_W'(HOPPER_TIMEOUT - 1);

    // BCD increment of a three-digit value; the hundreds digit never needs
    // to wrap because the count stops at the latched target.
    function automatic logic [11:0] bcd_inc12(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v[3:0] != 4'd9) begin
            r[3:0] = v[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (v[7:4] != 4'd9) begin
                r[7:4] = v[7:4] + 4'd1;
            end else begin
                r[7:4]  = 4'd0;
                r[11:8] = v[11:8] + 4'd1;
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] bcd_inc8(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (v[3:0] != 4'd9) begin
            r[3:0] = v[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            r[7:4] = v[7:4] + 4'd1;
        end
        return r;
    endfunction

    state_t             r_state,   w_state;
    logic [11:0]        r_pills,   w_pills;
    logic [7:0]         r_bottles, w_bottles;
    logic [11:0]        r_tp,      w_tp;
    logic [7:0]         r_tb,      w_tb;
    logic [TMR_W-1:0]   r_wd,      w_wd;
    logic               r_starve,  w_starve;
    logic               r_full;
    logic               r_done;

    logic [11:0]        w_pills_inc;
    logic [7:0]         w_bottles_inc;
    logic [TMR_W-1:0]   w_wd_inc;

    assign w_pills_inc   = bcd_inc12(r_pills);
    assign w_bottles_inc = bcd_inc8(r_bottles);
    // Saturating watchdog step.
    assign w_wd_inc      = (r_wd == c_wd_max) ? c_wd_max : r_wd + TMR_W'(1);

    always_ff @(posedge clk_1khz or negedge switch_clr) begin
        if (!switch_clr) begin
            r_state   <= IDLE;
            r_pills   <= '0;
            r_bottles <= '0;
            r_tp      <= '0;
            r_tb      <= '0;
            r_wd      <= '0;
            r_starve  <= 1'b0;
            r_full    <= 1'b0;
            r_done    <= 1'b0;
        end else if (clear) begin
            r_state   <= IDLE;
            r_pills   <= '0;
            r_bottles <= '0;
            r_tp      <= '0;
            r_tb      <= '0;
            r_wd      <= '0;
            r_starve  <= 1'b0;
            r_full    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_pills   <= w_pills;
            r_bottles <= w_bottles;
            r_tp      <= w_tp;
            r_tb      <= w_tb;
            r_wd      <= w_wd;
            r_starve  <= w_starve;
            // Flags are registered from the next state so they appear on
            // the same edge as the count that caused them.
            r_full    <= (w_state == FULL);
            r_done    <= (w_state == DONE);
        end
    end

    always_comb begin
        w_state   = r_state;
        w_pills   = r_pills;
        w_bottles = r_bottles;
        w_tp      = r_tp;
        w_tb      = r_tb;
        w_wd      = r_wd;
        w_starve  = r_starve;
        case (r_state)
            IDLE: begin
                if (count_en) begin
                    w_tp = target_pills;
                    w_tb = target_bottles;
                    w_wd = '0;
                    if ((target_pills == 12'h000) || (target_bottles == 8'h00)) begin
                        w_state = DONE;
                    end else begin
                        w_state = FILL;
                    end
                end
            end
            FILL: begin
                // count_en low pauses everything, including the watchdog.
                if (count_en) begin
                    if (hopper_pulse) begin
                        w_pills  = w_pills_inc;
                        w_wd     = '0;
                        w_starve = 1'b0;
                        if (w_pills_inc == r_tp) begin
                            w_bottles = w_bottles_inc;
                            w_state   = (w_bottles_inc == r_tb) ? DONE : FULL;
                        end
                    end else begin
                        w_wd = w_wd_inc;
                        if (w_wd_inc == c_wd_max) begin
                            w_starve = 1'b1;
                        end
                    end
                end
            end
            FULL: begin
                w_wd     = '0;
                w_starve = 1'b0;
                // Ack does not need count_en; a coincident pulse is dropped.
                if (bottle_ack) begin
                    w_pills = '0;
                    w_state = FILL;
                end
            end
            DONE: begin
                // Frozen until clear or reset.
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign now_pills   = r_pills;
    assign now_bottles = r_bottles;
    assign bottle_full = r_full;
    assign batch_done  = r_done;
    assign starve      = r_starve;
    assign state_o     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_bottle_fill_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bottle_fill_counter
//  Description : Self-checking bench for bottle_fill_counter. A decimal
//                reference model predicts each cycle's outputs; predictions
//                are queued when stimulus is driven and popped and compared
//                after the clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bottle_fill_counter;

    localparam int HT = 3000;

    logic        clk_1khz;
    logic        switch_clr;
    logic        clear;
    logic        count_en;
    logic        hopper_pulse;
    logic        bottle_ack;
    logic [11:0] target_pills;
    logic [7:0]  target_bottles;
    logic [11:0] now_pills;
    logic [7:0]  now_bottles;
    logic        bottle_full;
    logic        batch_done;
    logic        starve;
    logic [1:0]  state_o;

    bottle_fill_counter #(.HOPPER_TIMEOUT(HT), .TMR_W(12)) dut (
        .clk_1khz      (clk_1khz),
        .switch_clr    (switch_clr),
        .clear         (clear),
        .count_en      (count_en),
        .hopper_pulse  (hopper_pulse),
        .bottle_ack    (bottle_ack),
        .target_pills  (target_pills),
        .target_bottles(target_bottles),
        .now_pills     (now_pills),
        .now_bottles   (now_bottles),
        .bottle_full   (bottle_full),
        .batch_done    (batch_done),
        .starve        (starve),
        .state_o       (state_o)
    );

    initial clk_1khz = 1'b0;
    always #5 clk_1khz = ~clk_1khz;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, kept in plain decimal.
    int m_state, m_pills, m_bottles, m_tp, m_tb, m_wd;
    bit m_starve;

    logic [24:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int bcd2int(input logic [11:0] v);
        return 100 * int'(v[11:8]) + 10 * int'(v[7:4]) + int'(v[3:0]);
    endfunction

    function automatic logic [11:0] int2bcd(input int n);
        logic [3:0] h, t, o;
        h = 4'(n / 100);
        t = 4'((n / 10) % 10);
        o = 4'(n % 10);
        return {h, t, o};
    endfunction

    function automatic logic [24:0] observed();
        return {state_o, starve, batch_done, bottle_full, now_bottles, now_pills};
    endfunction

    function automatic logic [24:0] predicted();
        logic [11:0] b;
        b = int2bcd(m_bottles);
        return {2'(m_state), m_starve, (m_state == 3), (m_state == 2), b[7:0], int2bcd(m_pills)};
    endfunction

    task automatic model_reset();
        m_state = 0; m_pills = 0; m_bottles = 0;
        m_tp = 0; m_tb = 0; m_wd = 0; m_starve = 0;
    endtask

    // One clock of the reference model using the currently driven inputs.
    task automatic model_step();
        if (clear) begin
            model_reset();
        end else begin
            case (m_state)
                0: if (count_en) begin
                    m_tp = bcd2int(target_pills);
                    m_tb = bcd2int({4'd0, target_bottles});
                    m_wd = 0;
                    m_state = (m_tp == 0 || m_tb == 0) ? 3 : 1;
                end
                1: if (count_en) begin
                    if (hopper_pulse) begin
                        m_pills++;
                        m_wd = 0;
                        m_starve = 0;
                        if (m_pills == m_tp) begin
                            m_bottles++;
                            m_state = (m_bottles == m_tb) ? 3 : 2;
                        end
                    end else begin
                        if (m_wd < HT - 1) m_wd++;
                        if (m_wd == HT - 1) m_starve = 1;
                    end
                end
                2: begin
                    m_wd = 0;
                    m_starve = 0;
                    if (bottle_ack) begin
                        m_pills = 0;
                        m_state = 1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    // Drive one cycle, predict, then compare after the edge.
    task automatic cyc(input bit en, input bit pulse, input bit ack, input bit clr);
        logic [24:0] e;
        @(negedge clk_1khz);
        count_en     = en;
        hopper_pulse = pulse;
        bottle_ack   = ack;
        clear        = clr;
        model_step();
        exp_q.push_back(predicted());
        @(posedge clk_1khz);
        #1;
        e = exp_q.pop_front();
        check("cycle", 32'(observed()), 32'(e));
    endtask

    task automatic pulses(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            cyc(1, 1, 0, 0);
            for (int j = 1; j < gap; j++) cyc(1, 0, 0, 0);
        end
    endtask

    task automatic start(input logic [11:0] tp, input logic [7:0] tbt);
        cyc(0, 0, 0, 1);
        target_pills   = tp;
        target_bottles = tbt;
        cyc(1, 0, 0, 0);
    endtask

    initial begin
        int n;
        switch_clr = 1'b0; clear = 1'b0; count_en = 1'b0;
        hopper_pulse = 1'b0; bottle_ack = 1'b0;
        target_pills = 12'h003; target_bottles = 8'h02;
        model_reset();
        #12;
        check("reset_state", 32'(observed()), 32'd0);
        @(negedge clk_1khz);
        switch_clr = 1'b1;

        // 1: 003/02, three pulses five apart; later target changes ignored.
        cyc(1, 0, 0, 0);
        target_pills = 12'h009;
        pulses(2, 5);
        cyc(1, 1, 0, 0);
        check("t1_full", 32'(bottle_full), 32'd1);
        check("t1_pills", 32'(now_pills), 32'h003);
        check("t1_bottles", 32'(now_bottles), 32'h01);

        // 2: ack, three more pulses -> done; extra pulses ignored.
        cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        check("t2_ack_pills", 32'(now_pills), 32'h000);
        pulses(3, 2);
        check("t2_done", 32'(batch_done), 32'd1);
        pulses(3, 1);
        check("t2_frozen", 32'(now_pills), 32'h003);

        // 3: BCD carries up to 120.
        start(12'h120, 8'h01);
        pulses(9, 2);
        check("t3_009", 32'(now_pills), 32'h009);
        pulses(90, 1);
        check("t3_099", 32'(now_pills), 32'h099);
        pulses(21, 1);
        check("t3_120", 32'(now_pills), 32'h120);
        check("t3_done", 32'(batch_done), 32'd1);

        // 4: watchdog latency after the second pulse.
        start(12'h005, 8'h01);
        pulses(1, 3);
        cyc(1, 1, 0, 0);
        n = 0;
        while (starve !== 1'b1 && n < HT + 10) begin
            cyc(1, 0, 0, 0);
            n++;
        end
        check("t4_starve_lat", 32'(n), 32'(HT - 1));
        cyc(1, 1, 0, 0);
        check("t4_starve_clr", 32'(starve), 32'd0);
        check("t4_pills", 32'(now_pills), 32'h003);

        // 5a: long pause in FILL with pulses that must be ignored.
        for (int i = 0; i < 5000; i++) cyc(0, (i % 100) == 7, 0, 0);
        check("t5_pause_pills", 32'(now_pills), 32'h003);
        check("t5_pause_starve", 32'(starve), 32'd0);

        // 5b: zero pill target -> DONE on first enabled cycle.
        start(12'h000, 8'h05);
        check("t5_zero_done", 32'(state_o), 32'd3);

        // 5c: pulse while FULL ignored; pulse+ack -> ack only.
        start(12'h002, 8'h03);
        pulses(2, 2);
        cyc(1, 1, 0, 0);
        check("t5_full_hold", 32'(now_pills), 32'h002);
        cyc(1, 1, 1, 0);
        check("t5_ack_pills", 32'(now_pills), 32'h000);
        check("t5_ack_state", 32'(state_o), 32'd1);

        // 6: async reset mid-fill.
        start(12'h005, 8'h01);
        pulses(2, 2);
        @(negedge clk_1khz);
        #2;
        switch_clr = 1'b0;
        #1;
        model_reset();
        check("t6_async", 32'(observed()), 32'd0);
        @(negedge clk_1khz);
        switch_clr = 1'b1;

        // 6: sync clear, then re-latch new targets.
        target_pills = 12'h004;
        cyc(1, 0, 0, 0);
        pulses(2, 2);
        cyc(1, 0, 0, 1);
        check("t6_clear", 32'(observed()), 32'd0);
        target_pills = 12'h002; target_bottles = 8'h01;
        cyc(1, 0, 0, 0);
        pulses(2, 2);
        check("t6_relatch", 32'(batch_done), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL timeout: got running expected finished");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

endmodule
`default_nettype wire
